// File: rtl/ws2812_receiver.sv
// WS2812 serial LED stream decoder: measures DIN high pulse widths to recover
// pixel words, and reports the frame's pixel count at each latch gap.
module ws2812_receiver #(
    parameter int BITS   = 24,
    parameter int PIXELS = 256,
    parameter int NSS    = 64,
    parameter int THRESH = 27,
    parameter int LATCH  = 320
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            DIN,
    output logic [BITS-1:0] DATA,
    output logic [7:0]      PIXEL,
    output logic            VALID,
    output logic [8:0]      COUNT,
    output logic            FRAME_DONE,
    output logic            ERR,
    output logic            OVERRUN
);

    localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [1:0] {WAIT_GAP, IDLE_LOW, HIGH} state_t;

    state_t          state, state_n;
    logic            din_m, din_s, din_d;
    logic            rise, fall, bitv, gap;
    logic [15:0]     lcnt, lcnt_n;
    logic [7:0]      hcnt, hcnt_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic [8:0]      pcnt, pcnt_n;
    logic [BITS-1:0] sreg, sreg_n, shifted;
    logic [BITS-1:0] data_n;
    logic [7:0]      pixel_n;
    logic [8:0]      count_n;
    logic            valid_n, done_n, err_n, ovr_n;

    always_comb begin
        rise    = !din_d && din_s;
        fall    = din_d && !din_s;
        bitv    = 32'(hcnt) >= THRESH;
        shifted = {sreg[BITS-2:0], bitv};
        // Fires only on the LATCH-th consecutive low sample, so once per low period.
        gap     = !din_s && (32'(lcnt) == LATCH - 1);
        if (din_s)
            lcnt_n = '0;
        else if (lcnt != 16'hFFFF)
            lcnt_n = lcnt + 16'd1;
        else
            lcnt_n = lcnt;
    end

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        bcnt_n  = bcnt;
        pcnt_n  = pcnt;
        sreg_n  = sreg;
        data_n  = DATA;
        pixel_n = PIXEL;
        count_n = COUNT;
        valid_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        ovr_n   = OVERRUN;
        if (gap && state != HIGH) begin
            state_n = IDLE_LOW;
            count_n = pcnt;
            done_n  = (pcnt != '0);
            err_n   = (bcnt != '0);
            pcnt_n  = '0;
            bcnt_n  = '0;
            sreg_n  = '0;
            ovr_n   = 1'b0;
        end
        case (state)
            WAIT_GAP: ;
            IDLE_LOW: begin
                if (rise) begin
                    state_n = HIGH;
                    hcnt_n  = 8'd1;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_n = IDLE_LOW;
                    sreg_n  = shifted;
                    if (32'(bcnt) == BITS - 1) begin
                        bcnt_n = '0;
                        if (32'(pcnt) < PIXELS) begin
                            data_n  = shifted;
                            pixel_n = pcnt[7:0];
                            valid_n = 1'b1;
                            pcnt_n  = pcnt + 9'd1;
                        end else begin
                            ovr_n = 1'b1;
                        end
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end else if (din_s) begin
                    // Over-long pulse: drop the partial pixel and resync on the next gap.
                    if (32'(hcnt) >= NSS) begin
                        err_n   = 1'b1;
                        bcnt_n  = '0;
                        sreg_n  = '0;
                        state_n = WAIT_GAP;
                    end else if (hcnt != 8'hFF) begin
                        hcnt_n = hcnt + 8'd1;
                    end
                end
            end
            default: state_n = WAIT_GAP;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            din_m      <= 1'b0;
            din_s      <= 1'b0;
            din_d      <= 1'b0;
            state      <= WAIT_GAP;
            lcnt       <= '0;
            hcnt       <= '0;
            bcnt       <= '0;
            pcnt       <= '0;
            sreg       <= '0;
            DATA       <= '0;
            PIXEL      <= '0;
            COUNT      <= '0;
            VALID      <= 1'b0;
            FRAME_DONE <= 1'b0;
            ERR        <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            din_m      <= DIN;
            din_s      <= din_m;
            din_d      <= din_s;
            state      <= state_n;
            lcnt       <= lcnt_n;
            hcnt       <= hcnt_n;
            bcnt       <= bcnt_n;
            pcnt       <= pcnt_n;
            sreg       <= sreg_n;
            DATA       <= data_n;
            PIXEL      <= pixel_n;
            COUNT      <= count_n;
            VALID      <= valid_n;
            FRAME_DONE <= done_n;
            ERR        <= err_n;
            OVERRUN    <= ovr_n;
        end
    end

endmodule
